avalon_st_pkt_tx: RTL
=====================

// Module: avalon_st_pkt_tx
// PURPOSE
//  Avalon-ST packet transmitter: captures a parallel bank of up to BEATS words and
//  streams it out as one packet (valid/ready, sop/eop, empty), one word per beat.
//  Transmit-side counterpart of avalon_st_sink's reg_out bank: drives avalon_st_sink
//  (or any ready-latency-0 Avalon-ST sink) from a register-level producer.
// PARAMETERS
//  WIDTH    64                   data bus width in bits (multiple of 8)
//  BEATS    4                    max beats per packet / depth of load bank
//  EMPTY_W  $clog2(WIDTH/8)      width of empty (3 for WIDTH=64)
//  LEN_W    $clog2(BEATS)+1      width of load_beats
//  CNT_W    32                   width of pkt_count (AVST_TX_PKT_CNT_EN only)
// PORTS
//  clk        in   1                  single clock, all logic on rising edge
//  rst        in   1                  synchronous, active-high reset
//  load       in   1                  request to capture a new packet
//  load_data  in   [BEATS-1:0][WIDTH-1:0]  packet words, index 0 sent first
//  load_beats in   LEN_W              beats in packet, legal 1..BEATS
//  load_empty in   EMPTY_W            empty bytes on final beat
//  busy       out  1                  1 while a packet is held/being sent
//  load_err   out  1                  1-cycle pulse: load rejected (illegal length)
//  data       out  WIDTH              Avalon-ST data
//  valid      out  1                  Avalon-ST valid
//  ready      in   1                  Avalon-ST ready (ready latency 0)
//  sop        out  1                  start of packet, beat 0 only
//  eop        out  1                  end of packet, final beat only
//  empty      out  EMPTY_W            load_empty on eop beat, else 0
//  pkt_count  out  CNT_W              completed packets (AVST_TX_PKT_CNT_EN only)
// BEHAVIOUR
//  - FSM: IDLE, SEND. Reset -> IDLE; busy, valid, sop, eop, load_err = 0;
//    data, empty = 0; beat index = 0; pkt_count = 0.
//  - IDLE: load=1 and 1<=load_beats<=BEATS -> register load_data/beats/empty,
//    index=0, go SEND. valid rises the cycle after load (latency 1).
//  - IDLE: load=1 with load_beats=0 or >BEATS -> stay IDLE, load_err=1 next cycle.
//  - SEND: valid=1, busy=1, data=bank[index]; sop=(index==0);
//    eop=(index==len-1); empty=eop?stored_empty:0. 1-beat packet: sop=eop=1.
//  - Transfer occurs on cycle with valid&&ready; index increments; on final
//    transfer -> IDLE, valid/busy/eop drop next cycle.
//  - valid&&!ready: data/sop/eop/empty held stable, no beat skipped or repeated.
//  - load while busy (incl. final-transfer cycle): ignored, bank unchanged, no
//    load_err. Min one idle cycle between packets.
//  - ready while valid=0: no effect. valid never depends combinationally on ready.
//  - rst mid-packet: abort immediately, next cycle all outputs at reset values;
//    no eop emitted for aborted packet; pkt_count cleared.
// CONFIGURATION
//  AVST_TX_PKT_CNT_EN defined: pkt_count port present; increments by 1 on each
//    eop transfer (valid&&ready&&eop), wraps 2^CNT_W-1 -> 0, not incremented by aborts.
//  Undefined: pkt_count port and counter logic absent; all else identical.
// TESTING
//  1. rst=1 2 cycles -> valid=sop=eop=busy=0, data=0, empty=0.
//  2. load, beats=4, data={0x..33,0x..22,0x..11,0x..00}, empty=2, ready=1 ->
//     4 consecutive beats 0x..00..0x..33, sop on beat0, eop+empty=2 on beat3.
//  3. Same packet, ready toggling 1,0,0,1,0,1,1 -> each word appears once, held
//     stable while ready=0, order preserved, eop only on 4th accepted beat.
//  4. load beats=1, data=0xDEADBEEF_CAFEF00D, empty=5 -> single beat sop=eop=1,
//     empty=5; load beats=0 and beats=5 -> load_err pulse, valid stays 0.
//  5. load during SEND with different data -> ignored, original packet intact;
//     rst asserted after beat 1 -> valid=0 next cycle, no eop seen by sink.
//  6. AVST_TX_PKT_CNT_EN, CNT_W=4: send 17 packets -> pkt_count=1 (wrap);
//     packet aborted by rst -> pkt_count=0.

Source files
------------

// File: rtl/avalon_st_pkt_tx.sv
// avalon_st_pkt_tx: Avalon-ST packet transmitter.
// Captures a bank of up to BEATS words on a load request and streams them out
// as one packet (valid/ready, sop/eop, empty) with ready latency 0.
// Optional packet counter: define AVST_TX_PKT_CNT_EN to add o_pkt_count.
module avalon_st_pkt_tx #(
    parameter int WIDTH   = 64,
    parameter int BEATS   = 4,
    parameter int EMPTY_W = $clog2(WIDTH/8),
    parameter int LEN_W   = $clog2(BEATS) + 1
`ifdef AVST_TX_PKT_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_load,
    input  logic [BEATS-1:0][WIDTH-1:0]  i_load_data,
    input  logic [LEN_W-1:0]             i_load_beats,
    input  logic [EMPTY_W-1:0]           i_load_empty,
    output logic                         o_busy,
    output logic                         o_load_err,
`ifdef AVST_TX_PKT_CNT_EN
    output logic [CNT_W-1:0]             o_pkt_count,
`endif
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_sop,
    output logic                         o_eop,
    output logic [EMPTY_W-1:0]           o_empty
);

    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                  r_state;
    logic [BEATS-1:0][WIDTH-1:0] r_bank;
    logic [LEN_W-1:0]            r_last;
    logic [EMPTY_W-1:0]          r_empty;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_load_err;

    logic                        w_send;
    logic                        w_legal;
    logic                        w_eop;

    assign w_send  = (r_state == ST_SEND);
    assign w_legal = (i_load_beats != '0) && (i_load_beats <= LEN_W'(BEATS));
    assign w_eop   = w_send && (LEN_W'(r_idx) == r_last);

    // Packet capture in IDLE, beat sequencing in SEND; loads while sending are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_bank     <= '0;
            r_last     <= '0;
            r_empty    <= '0;
            r_idx      <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        if (w_legal) begin
                            r_bank  <= i_load_data;
                            r_last  <= i_load_beats - LEN_W'(1);
                            r_empty <= i_load_empty;
                            r_idx   <= '0;
                            r_state <= ST_SEND;
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (i_ready) begin
                        if (w_eop) begin
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode purely from registered state, so valid never follows ready.
    assign o_valid    = w_send;
    assign o_busy     = w_send;
    assign o_data     = w_send ? r_bank[r_idx] : '0;
    assign o_sop      = w_send && (r_idx == '0);
    assign o_eop      = w_eop;
    assign o_empty    = w_eop ? r_empty : '0;
    assign o_load_err = r_load_err;

`ifdef AVST_TX_PKT_CNT_EN
    logic [CNT_W-1:0] r_pkt_count;

    // Count completed packets (accepted eop beats); wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pkt_count <= '0;
        end else if (w_eop && i_ready) begin
            r_pkt_count <= r_pkt_count + CNT_W'(1);
        end
    end

    assign o_pkt_count = r_pkt_count;
`endif

endmodule
